// File: rtl/dc_pwm.sv
// Duty-cycle PWM generator: eight-slot period with a prescaled slot clock.
// The applied duty is reloaded (directly or by one-step ramping) only at period boundaries.
module dc_pwm #(
    parameter int PRESCALE = 4,
    parameter int RAMP     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] dc_control,
    output logic       pwm,
    output logic [2:0] trigger,
    output logic       period_start,
    output logic [2:0] duty_applied
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_presc;
    logic [7:0] w_presc_nxt;
    logic [2:0] r_phase;
    logic [2:0] w_phase_nxt;
    logic [2:0] r_duty;
    logic [2:0] w_duty_nxt;
    logic       w_tick;
    logic       w_load;

    // Ramping moves one step toward the target and never overshoots or wraps.
    function automatic logic [2:0] f_next_duty(input logic [2:0] target, input logic [2:0] cur);
        logic [2:0] res;
        if (RAMP == 0) begin
            res = target;
        end else if (target > cur) begin
            res = cur + 3'd1;
        end else if (target < cur) begin
            res = cur - 3'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Counter and duty next values; en low always clears, so no load can coincide with leaving RUN
    always_comb begin
        w_tick      = (r_presc == PS_LAST);
        w_load      = 1'b0;
        w_presc_nxt = 8'd0;
        w_phase_nxt = 3'd0;
        w_duty_nxt  = 3'd0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_load     = 1'b1;
                    w_duty_nxt = f_next_duty(dc_control, r_duty);
                end else begin
                    w_duty_nxt = 3'd0;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (w_tick) begin
                        w_presc_nxt = 8'd0;
                        w_phase_nxt = r_phase + 3'd1;
                    end else begin
                        w_presc_nxt = r_presc + 8'd1;
                        w_phase_nxt = r_phase;
                    end
                    w_load = w_tick && (r_phase == 3'd7);
                    if (w_load) begin
                        w_duty_nxt = f_next_duty(dc_control, r_duty);
                    end else begin
                        w_duty_nxt = r_duty;
                    end
                end else begin
                    w_duty_nxt = 3'd0;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_presc <= 8'd0;
            r_phase <= 3'd0;
            r_duty  <= 3'd0;
        end else begin
            r_presc <= w_presc_nxt;
            r_phase <= w_phase_nxt;
            r_duty  <= w_duty_nxt;
        end
    end

    // Output decode from registered state only
    always_comb begin
        trigger      = r_phase;
        duty_applied = r_duty;
        if (r_state == ST_RUN) begin
            pwm          = (r_phase < r_duty);
            period_start = (r_phase == 3'd0) && (r_presc == 8'd0);
        end else begin
            pwm          = 1'b0;
            period_start = 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_pwm.sv
// Scoreboard bench for dc_pwm: three instances cover direct load, slow prescale and ramping.
module tb_dc_pwm;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      en_v;
    logic [2:0][2:0] dc_v;
    logic [2:0]      pwm_v;
    logic [2:0]      ps_v;
    logic [2:0][2:0] trig_v;
    logic [2:0][2:0] duty_v;

    always #5 clk = ~clk;

    dc_pwm #(.PRESCALE(1), .RAMP(0)) u_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .dc_control(dc_v[0]),
        .pwm(pwm_v[0]), .trigger(trig_v[0]), .period_start(ps_v[0]), .duty_applied(duty_v[0])
    );
    dc_pwm #(.PRESCALE(4), .RAMP(0)) u_b (
        .clk(clk), .rst(rst), .en(en_v[1]), .dc_control(dc_v[1]),
        .pwm(pwm_v[1]), .trigger(trig_v[1]), .period_start(ps_v[1]), .duty_applied(duty_v[1])
    );
    dc_pwm #(.PRESCALE(1), .RAMP(1)) u_c (
        .clk(clk), .rst(rst), .en(en_v[2]), .dc_control(dc_v[2]),
        .pwm(pwm_v[2]), .trigger(trig_v[2]), .period_start(ps_v[2]), .duty_applied(duty_v[2])
    );

    typedef struct {
        int         dut;
        logic       pwm;
        logic [2:0] trig;
        logic       ps;
        logic [2:0] duty;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic exp_t mk(int d, int p, int t, int s, int du, string tag);
        exp_t e;
        e.dut  = d;
        e.pwm  = (p != 0);
        e.trig = 3'(t);
        e.ps   = (s != 0);
        e.duty = 3'(du);
        e.tag  = tag;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        n_checks++;
        if (pwm_v[e.dut] !== e.pwm || trig_v[e.dut] !== e.trig ||
            ps_v[e.dut] !== e.ps || duty_v[e.dut] !== e.duty) begin
            n_errors++;
            $display("FAIL %s dut%0d t=%0t: got pwm=%b trig=%0d ps=%b duty=%0d, want pwm=%b trig=%0d ps=%b duty=%0d",
                     e.tag, e.dut, $time, pwm_v[e.dut], trig_v[e.dut], ps_v[e.dut], duty_v[e.dut],
                     e.pwm, e.trig, e.ps, e.duty);
        end
    endtask

    // Expected outputs while running: pwm high for slots below the applied duty
    task automatic push_run(int d, int ph, int first, int duty, string tag);
        q.push_back(mk(d, (ph < duty) ? 1 : 0, ph, first, duty, tag));
    endtask

    task automatic push_zero(int d, string tag);
        q.push_back(mk(d, 0, 0, 0, 0, tag));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                mon_e = q.pop_front();
                compare(mon_e);
            end
        end
    end

    initial begin
        int duty;
        int p;
        rst  = 1'b1;
        en_v = 3'b111;
        dc_v = {3'd5, 3'd5, 3'd5};
        #1 rst = 1'b0;

        // Reset held with en high
        tick();
        for (int d = 0; d < 3; d++) push_zero(d, "reset_hold");
        tick();
        for (int d = 0; d < 3; d++) push_zero(d, "reset_hold2");
        rst  = 1'b1;
        en_v = 3'b000;
        tick();
        for (int d = 0; d < 3; d++) push_zero(d, "idle");
        tick();

        // PRESCALE=1 direct: duty 3, then 0, then 7
        dc_v[0] = 3'd3;
        en_v[0] = 1'b1;
        tick();
        for (int k = 0; k < 80; k++) begin
            if (k == 24) dc_v[0] = 3'd0;
            if (k == 56) dc_v[0] = 3'd7;
            duty = (k < 32) ? 3 : ((k < 64) ? 0 : 7);
            push_run(0, k % 8, (k % 8 == 0) ? 1 : 0, duty, "A_p1");
            tick();
        end
        en_v[0] = 1'b0;
        push_run(0, 0, 1, 7, "A_p1_last");
        tick();
        push_zero(0, "A_off");
        tick();

        // PRESCALE=4: change 3->6 while trigger is 4
        dc_v[1] = 3'd3;
        en_v[1] = 1'b1;
        tick();
        for (int n = 0; n < 64; n++) begin
            duty = (n < 32) ? 3 : 6;
            push_run(1, (n / 4) % 8, (n % 32 == 0) ? 1 : 0, duty, "B_p4");
            if (n == 16) dc_v[1] = 3'd6;
            tick();
        end
        en_v[1] = 1'b0;
        push_run(1, 0, 1, 6, "B_p4_last");
        tick();
        push_zero(1, "B_off");
        tick();

        // Ramp: 1..5 then down to 2
        dc_v[2] = 3'd5;
        en_v[2] = 1'b1;
        tick();
        for (int k = 0; k < 88; k++) begin
            p = k / 8;
            if (k == 48) dc_v[2] = 3'd2;
            if (p < 6) duty = (p + 1 < 5) ? p + 1 : 5;
            else if (p == 6) duty = 5;
            else duty = (11 - p > 2) ? 11 - p : 2;
            push_run(2, k % 8, (k % 8 == 0) ? 1 : 0, duty, "C_ramp");
            tick();
        end
        en_v[2] = 1'b0;
        tick();
        push_zero(2, "C_off");
        tick();

        // en dropped at trigger 2 with duty 5, then re-raised
        dc_v[0] = 3'd5;
        en_v[0] = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            push_run(0, k, (k == 0) ? 1 : 0, 5, "D_run");
            if (k == 2) en_v[0] = 1'b0;
            tick();
        end
        push_zero(0, "D_drop");
        en_v[0] = 1'b1;
        tick();
        push_run(0, 0, 1, 5, "D_restart0");
        tick();
        push_run(0, 1, 0, 5, "D_restart1");
        tick();
        push_run(0, 2, 0, 5, "D_restart2");

        // Asynchronous reset mid-period, checked before any clock edge
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        compare(mk(0, 0, 0, 0, 0, "async_reset"));
        tick();
        push_zero(0, "reset_held_run");
        tick();
        rst  = 1'b1;
        en_v = 3'b000;
        tick();

        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dc_pwm.md
Name: dc_pwm

Overview:
- Consumer end of the 3-bit duty-cycle control interface. Reads the stored `dc_control` level and produces a glitch-free PWM output for the motor driver.
- Also generates the 3-bit `trigger` phase count. The duty store uses `trigger == 0` as its update window.
- Duty changes take effect only at period boundaries. Optional soft-start ramping limits each change to one step per period.

Parameters:
- PRESCALE, 4, clock cycles per PWM slot; legal range 1..256; one period = 8*PRESCALE clocks.
- RAMP, 0, 0 = load target duty directly at each boundary; 1 = move applied duty at most ±1 per period toward target.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- en  input  1  run enable, sampled on clk.
- dc_control  input  3  target duty, 0..7 slots of 8; sampled only at period boundaries.
- pwm  output  1  PWM drive.
- trigger  output  3  current slot index 0..7; feeds the duty store.
- period_start  output  1  high for exactly one clock, the first clock of slot 0 of each period.
- duty_applied  output  3  duty in force for the current period.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE; prescale counter = 0; phase = 0; duty_applied = 0.
  - Outputs: pwm = 0, trigger = 0, period_start = 0.
  - Takes effect immediately and overrides everything, including mid-period.
- State machine: two states, IDLE and RUN.
- IDLE:
  - Counters held at 0; duty_applied held at 0; pwm = 0; period_start = 0.
  - Edge with en = 1: go to RUN, with prescale counter = 0 and phase = 0.
  - On that same edge, apply the duty update rule (a "boundary load").
- RUN, per edge:
  - If en = 0: go to IDLE and clear counters and duty_applied.
  - Otherwise increment the prescale counter.
  - When the prescale counter = PRESCALE-1 (a "tick"): prescale counter wraps to 0 and phase increments.
  - Tick with phase = 7: phase wraps to 0 and a boundary load occurs on the same edge.
  - PRESCALE = 1: every enabled edge is a tick.
- Duty update rule at a boundary load:
  - RAMP = 0: duty_applied <= dc_control.
  - RAMP = 1: if dc_control > duty_applied, add 1; if less, subtract 1; if equal, hold.
  - No wrap: duty_applied stays within 0..7 and never overshoots the target.
- Output decode (combinational from registered state only; no path from dc_control or en):
  - trigger = phase.
  - pwm = (state == RUN) && (phase < duty_applied).
  - period_start = (state == RUN) && phase == 0 && prescale counter == 0.
- Duty range:
  - duty 0 gives constant low.
  - duty 7 gives 7/8 high; slot 7 is always low, so a 100% duty is impossible by design.
  - High time per period = duty_applied * PRESCALE clocks, starting at period_start.
- Timing:
  - A dc_control change mid-period has no effect until the next boundary load; the current period is never truncated or extended.
  - en falling: pwm, trigger and period_start drop to 0 one clock after en is sampled low.
  - en rising: period_start is high in the first clock after the IDLE→RUN edge.
- Simultaneous events: en = 0 sampled on a boundary edge means go to IDLE; no boundary load occurs.

Test Plan:
- Reset: hold rst = 0 with en = 1 and dc_control = 5 → pwm = 0, trigger = 0, duty_applied = 0, period_start = 0. Assert rst = 0 mid-period in RUN → all outputs 0 without waiting for a clock.
- PRESCALE = 1, RAMP = 0, dc_control = 3, raise en:
  - period_start pulses every 8 clocks.
  - trigger sequence is 0,1,…,7.
  - pwm is high on the 3 clocks with trigger 0..2.
  - duty_applied = 3.
- PRESCALE = 4, dc_control = 3→6 while trigger = 4:
  - The current period stays 12 clocks high, and each trigger value holds for 4 clocks.
  - The next period has duty_applied = 6 and is 24 clocks high of 32.
- Extremes, PRESCALE = 1: dc_control = 0 → pwm never high across 3 periods. dc_control = 7 → 7 high, 1 low per period.
- RAMP = 1, PRESCALE = 1, start from IDLE with dc_control = 5:
  - duty_applied goes 1,2,3,4,5 on successive boundaries, then holds at 5.
  - Then set dc_control = 2 → duty_applied goes 4,3,2.
- en dropped at trigger = 2 with duty 5:
  - pwm and trigger are 0 on the next clock, and duty_applied = 0.
  - Re-raise en → period_start on the first RUN clock, and trigger restarts at 0.
